qpd_capture: RTL

Triggered sample-window acquisition stage that sits directly downstream of the quarter-period delay block. It detects the rising edge of that block's `trigger` output and captures a programmed number of ADC words at the measurement sample rate into an internal FIFO. The host-side readout drains the FIFO through a valid/ready interface.

---
 rtl/qpd_capture.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/qpd_capture.sv
// Triggered sample-window capture stage: a rising trigger edge starts a window of
// num_samples ADC captures at the sample rate into a first-word-fall-through FIFO.
module qpd_capture #(
    parameter int clk_frequency    = 100000000,
    parameter int sample_frequency = 100000,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int DEPTH            = 256,
    localparam int DIV             = clk_frequency / sample_frequency,
    localparam int DW              = $clog2(DIV),
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic                    sclock,
    input  logic                    rst,
    input  logic                    trigger,
    input  logic [15:0]             num_samples,
    input  logic [SAMPLE_WIDTH-1:0] adc_data,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [AW:0]             fifo_count,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_trig_d;
    logic                    r_armed;
    logic [DW-1:0]           r_div_cnt;
    logic [15:0]             r_smp_cnt;
    logic [15:0]             r_n_lat;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;

    logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;

    logic                    w_trig_edge;
    logic                    w_cap;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_rd_valid;

    // r_armed blocks a false edge when trigger is already high as reset releases.
    assign w_trig_edge = trigger & ~r_trig_d & r_armed;
    assign w_cap       = (r_state == S_CAPTURE) && (r_div_cnt == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_wr        = w_cap & ~w_full;
    assign w_rd_valid  = (r_count != '0);
    assign w_rd        = w_rd_valid & rd_ready;

    assign rd_valid    = w_rd_valid;
    assign rd_data     = w_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count  = r_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;

    // Window sequencing: trigger edge detect, sample-rate divider and sample count.
    always_ff @(posedge sclock or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_trig_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_div_cnt  <= '0;
            r_smp_cnt  <= 16'd0;
            r_n_lat    <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_trig_d <= trigger;
            r_done   <= 1'b0;
            if (!trigger) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trig_edge) begin
                        if (num_samples != 16'd0) begin
                            r_n_lat    <= num_samples;
                            r_div_cnt  <= '0;
                            r_smp_cnt  <= 16'd0;
                            r_overflow <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_CAPTURE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1'b1);
                    if (w_cap) begin
                        r_smp_cnt <= r_smp_cnt + 16'd1;
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_smp_cnt == r_n_lat - 16'd1) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; full is judged on the start-of-cycle count.
    always_ff @(posedge sclock or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW + 1)'(1'b1);
                2'b01:   r_count <= r_count - (AW + 1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, left unreset; rd_data is masked while empty.
    always_ff @(posedge sclock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

endmodule
